// File: rtl/formula_2_out_buffer_pkg.sv
// Shared constants and types for the formula_2 output buffer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package formula_2_pkg;

   localparam int OUT_WIDTH = 32;   // default result width
   localparam int OUT_DEPTH = 8;    // default result FIFO entries

   // Sized for the default depth: credits span 0..DEPTH, pointers 0..DEPTH-1.
   typedef logic [$clog2(OUT_DEPTH+1)-1:0] credit_t;
   typedef logic [$clog2(OUT_DEPTH)-1:0]   ptr_t;

endpackage

// File: rtl/formula_2_out_buffer_if.sv
// Handshake bundle between producer, formula pipe, output buffer and consumer.
// Latency: n/a (wires only).
// Backpressure: carries up_vld/up_rdy and out_vld/out_rdy; the pipe side has none.
// slave  : the buffer's view (takes up_vld, res_vld, res, out_rdy).
// master : the environment's view (drives those, observes the rest).
interface formula_2_out_buffer_if #(
   parameter int WIDTH = formula_2_pkg::OUT_WIDTH
);
   logic             up_vld;
   logic             up_rdy;
   logic             arg_vld;
   logic             res_vld;
   logic [WIDTH-1:0] res;
   logic             out_vld;
   logic [WIDTH-1:0] out_data;
   logic             out_rdy;
   logic             err_ovf;
   logic             err_unx;

   modport slave (
      input  up_vld, res_vld, res, out_rdy,
      output up_rdy, arg_vld, out_vld, out_data, err_ovf, err_unx
   );

   modport master (
      output up_vld, res_vld, res, out_rdy,
      input  up_rdy, arg_vld, out_vld, out_data, err_ovf, err_unx
   );
endinterface

// File: rtl/formula_2_out_buffer_fifo.sv
// Show-ahead result FIFO: storage, wrapping pointers, occupancy, full/empty.
// Latency: a push on edge N is visible on dout/!empty in the cycle after edge N.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
// Ports: clk, rst (async active-low), push/din, pop, dout (= mem[rd_ptr]), empty, full.
module formula_out_fifo
   import formula_2_pkg::*;
#(
   parameter int WIDTH = OUT_WIDTH,
   parameter int DEPTH = OUT_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_pop;
   logic             do_push;

   assign empty   = (count == '0);
   assign full    = (count == DEPTH_C);
   assign dout    = mem[rd_ptr];
   assign do_pop  = pop & ~empty;
   // A pop frees the head slot this cycle, so a full FIFO can still take a push.
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;   // power-of-two depth: natural wrap
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/formula_2_out_buffer.sv
// Credit controller + result buffer turning the fixed-latency formula pipe into a stream.
// Latency: 1 cycle from res_vld to out_vld (0 when bypassing an empty FIFO).
// Backpressure: up_rdy drops once DEPTH results are issued but not yet popped.
// Ports: clk, rst (async active-low), bus (slave modport: up/arg/res/out handshakes, sticky errors).
// Option: FORMULA_OUT_BUF_BYPASS_EN forwards res straight to the consumer when the FIFO is empty.
module formula_2_out_buffer
   import formula_2_pkg::*;
#(
   parameter int WIDTH = OUT_WIDTH,
   parameter int DEPTH = OUT_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   formula_2_out_buffer_if.slave  bus
);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [CW-1:0]    credits;
   logic [CW-1:0]    inflight;
   logic             issue;
   logic             res_ok;
   logic             bypass;
   logic             out_vld;
   logic             pop_fire;
   logic             fifo_push;
   logic             fifo_pop;
   logic             fifo_empty;
   logic             fifo_full;
   logic [WIDTH-1:0] fifo_dout;
   logic             err_ovf;
   logic             err_unx;

   // Issue only while a slot is reserved for every outstanding result.
   assign bus.up_rdy  = (credits < DEPTH_C);
   assign issue       = bus.up_vld & bus.up_rdy;
   assign bus.arg_vld = issue;

   // A result with nothing in flight is spurious and never reaches the FIFO.
   assign res_ok = bus.res_vld & (inflight != '0);

`ifdef FORMULA_OUT_BUF_BYPASS_EN
   assign bypass = fifo_empty & res_ok & bus.out_rdy;
`else
   assign bypass = 1'b0;
`endif

   assign out_vld      = ~fifo_empty | bypass;
   assign bus.out_vld  = out_vld;
   assign bus.out_data = bypass ? bus.res : fifo_dout;
   assign pop_fire     = out_vld & bus.out_rdy;
   assign fifo_pop     = ~fifo_empty & bus.out_rdy;
   assign fifo_push    = res_ok & ~bypass;

   assign bus.err_ovf = err_ovf;
   assign bus.err_unx = err_unx;

   formula_out_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .din   (bus.res),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         credits  <= '0;
         inflight <= '0;
         err_ovf  <= 1'b0;
         err_unx  <= 1'b0;
      end else begin
         case ({issue, pop_fire})
            2'b10:   credits <= credits + 1'b1;
            2'b01:   credits <= credits - 1'b1;
            default: credits <= credits;
         endcase
         case ({issue, res_ok})
            2'b10:   inflight <= inflight + 1'b1;
            2'b01:   inflight <= inflight - 1'b1;
            default: inflight <= inflight;
         endcase
         // Any result landing on a full FIFO without a same-cycle pop is lost.
         if (bus.res_vld & fifo_full & ~fifo_pop) err_ovf <= 1'b1;
         if (bus.res_vld & (inflight == '0))      err_unx <= 1'b1;
      end
   end
endmodule

// File: tb/tb_formula_2_out_buffer.sv
// Directed bench for formula_2_out_buffer: reset, single issue, credit fill, streaming,
// full-FIFO push/pop wrap, error injection, mid-operation reset, bypass/latency.
// Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
module tb_formula_2_out_buffer;
   import formula_2_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   formula_2_out_buffer_if #(.WIDTH(32)) bus ();

   formula_2_out_buffer #(.WIDTH(32), .DEPTH(8)) dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus)
   );

   // Stand-alone FIFO to exercise push+pop on a full FIFO across pointer wrap.
   logic        f_push, f_pop, f_empty, f_full;
   logic [31:0] f_din, f_dout;
   formula_out_fifo #(.WIDTH(32), .DEPTH(8)) u_fifo_ref (
      .clk   (clk),
      .rst   (rst_n),
      .push  (f_push),
      .din   (f_din),
      .pop   (f_pop),
      .dout  (f_dout),
      .empty (f_empty),
      .full  (f_full)
   );

   int checks = 0;
   int passes = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.up_vld  = 1'b0;
      bus.res_vld = 1'b0;
      bus.res     = '0;
      bus.out_rdy = 1'b0;
      f_push = 1'b0;
      f_pop  = 1'b0;
      f_din  = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Issue n argument sets with no consumer, then return n results base..base+n-1.
   task automatic fill(input int n, input logic [31:0] base);
      bus.out_rdy = 1'b0;
      bus.up_vld  = 1'b1;
      repeat (n) tick();
      bus.up_vld = 1'b0;
      for (int i = 0; i < n; i++) begin
         bus.res_vld = 1'b1;
         bus.res     = base + 32'(i);
         tick();
      end
      bus.res_vld = 1'b0;
      #1;
   endtask

   // Pop n entries, expecting base..base+n-1 in order; returns the number of misses.
   task automatic drain(input int n, input logic [31:0] base, output int errs);
      errs = 0;
      bus.out_rdy = 1'b1;
      for (int i = 0; i < n; i++) begin
         #1;
         if (!bus.out_vld || bus.out_data !== base + 32'(i)) errs++;
         tick();
      end
      bus.out_rdy = 1'b0;
      #1;
   endtask

   initial begin
      int n, e, drops, expv;
      credit_t zero_c;
      zero_c = '0;

      // ---------------- reset state ----------------
      idle();
      tick();
      tick();
      check("rst_up_rdy",   32'(bus.up_rdy),   32'd1);
      check("rst_arg_vld",  32'(bus.arg_vld),  32'd0);
      check("rst_out_vld",  32'(bus.out_vld),  32'd0);
      check("rst_out_data", bus.out_data,      32'd0);
      check("rst_err_ovf",  32'(bus.err_ovf),  32'd0);
      check("rst_err_unx",  32'(bus.err_unx),  32'd0);
      check("rst_credits",  32'(dut.credits),  32'(zero_c));
      rst_n = 1'b1;
      tick();

      // ---------------- single issue, result 0x2A ----------------
      bus.up_vld = 1'b1;
      #1 check("t1_arg_vld", 32'(bus.arg_vld), 32'd1);
      tick();
      bus.up_vld = 1'b0;
      check("t1_credits_one", 32'(dut.credits), 32'd1);
      tick();
      tick();
      bus.res_vld = 1'b1;
      bus.res     = 32'h2A;
      #1 check("t1_out_vld_same_cycle", 32'(bus.out_vld), 32'd0);
      tick();
      bus.res_vld = 1'b0;
      #1;
      check("t1_out_vld", 32'(bus.out_vld), 32'd1);
      check("t1_out_data", bus.out_data, 32'h2A);
      bus.out_rdy = 1'b1;
      tick();
      bus.out_rdy = 1'b0;
      #1;
      check("t1_out_vld_after_pop", 32'(bus.out_vld), 32'd0);
      check("t1_credits_zero", 32'(dut.credits), 32'd0);

      // ---------------- back-pressure fill ----------------
      bus.out_rdy = 1'b0;
      bus.up_vld  = 1'b1;
      n = 0;
      repeat (12) begin
         #1;
         if (bus.arg_vld) n++;
         tick();
      end
      check("t2_issue_count", 32'(n), 32'd8);
      check("t2_up_rdy_low", 32'(bus.up_rdy), 32'd0);
      for (int i = 0; i < 8; i++) begin
         bus.res_vld = 1'b1;
         bus.res     = 32'd16 + 32'(i);
         tick();
      end
      bus.res_vld = 1'b0;
      #1;
      check("t2_fifo_count", 32'(dut.u_fifo.count), 32'd8);
      bus.out_rdy = 1'b1;
      #1;
      check("t2_head", bus.out_data, 32'd16);
      check("t2_up_rdy_during_pop", 32'(bus.up_rdy), 32'd0);
      tick();
      bus.out_rdy = 1'b0;
      #1;
      check("t2_up_rdy_after_pop", 32'(bus.up_rdy), 32'd1);
      check("t2_reissue", 32'(bus.arg_vld), 32'd1);
      tick();
      bus.up_vld = 1'b0;
      #1 check("t2_up_rdy_full_again", 32'(bus.up_rdy), 32'd0);
      bus.res_vld = 1'b1;
      bus.res     = 32'd24;
      tick();
      bus.res_vld = 1'b0;
      drain(8, 32'd17, e);
      check("t2_drain_order", 32'(e), 32'd0);
      check("t2_credits_zero", 32'(dut.credits), 32'd0);

      // ---------------- streaming 1..100, pipe latency 3 ----------------
      drops = 0;
      e     = 0;
      expv  = 1;
      for (int c = 0; c < 106; c++) begin
         bus.out_rdy = 1'b1;
         bus.up_vld  = (c < 100);
         bus.res_vld = (c >= 3 && c < 103);
         bus.res     = 32'(c - 2);
         #1;
         if (!bus.up_rdy) drops++;
         if (bus.out_vld) begin
            if (bus.out_data !== 32'(expv)) e++;
            expv++;
         end
         tick();
      end
      idle();
      #1;
      check("t3_up_rdy_never_low", 32'(drops), 32'd0);
      check("t3_order", 32'(e), 32'd0);
      check("t3_count", 32'(expv - 1), 32'd100);
      check("t3_err_ovf", 32'(bus.err_ovf), 32'd0);
      check("t3_err_unx", 32'(bus.err_unx), 32'd0);
      check("t3_credits_zero", 32'(dut.credits), 32'd0);

      // ---------------- full FIFO push+pop across wrap ----------------
      for (int i = 0; i < 8; i++) begin
         f_push = 1'b1;
         f_din  = 32'(i);
         tick();
      end
      f_push = 1'b0;
      #1 check("t4_full", 32'(f_full), 32'd1);
      n = 0;
      e = 0;
      for (int i = 0; i < 20; i++) begin
         f_push = 1'b1;
         f_pop  = 1'b1;
         f_din  = 32'd8 + 32'(i);
         #1;
         if (f_dout !== 32'(i)) e++;
         tick();
         if (u_fifo_ref.count !== 4'd8) n++;
      end
      f_push = 1'b0;
      f_pop  = 1'b0;
      check("t4_order_wrap", 32'(e), 32'd0);
      check("t4_occupancy_held", 32'(n), 32'd0);
      e = 0;
      f_pop = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (f_dout !== 32'd20 + 32'(i)) e++;
         tick();
      end
      f_pop = 1'b0;
      #1;
      check("t4_tail_order", 32'(e), 32'd0);
      check("t4_empty", 32'(f_empty), 32'd1);

      // ---------------- error injection ----------------
      do_reset();
      bus.res_vld = 1'b1;
      bus.res     = 32'd77;
      tick();
      bus.res_vld = 1'b0;
      #1;
      check("t5_err_unx", 32'(bus.err_unx), 32'd1);
      check("t5_unx_dropped", 32'(bus.out_vld), 32'd0);
      tick();
      tick();
      check("t5_unx_sticky", 32'(bus.err_unx), 32'd1);
      fill(8, 32'd200);
      check("t5_ovf_before", 32'(bus.err_ovf), 32'd0);
      bus.res_vld = 1'b1;
      bus.res     = 32'hDEAD;
      tick();
      bus.res_vld = 1'b0;
      #1;
      check("t5_err_ovf", 32'(bus.err_ovf), 32'd1);
      check("t5_count_kept", 32'(dut.u_fifo.count), 32'd8);
      check("t5_head_kept", bus.out_data, 32'd200);
      drain(8, 32'd200, e);
      check("t5_contents_kept", 32'(e), 32'd0);
      check("t5_ovf_sticky", 32'(bus.err_ovf), 32'd1);

      // ---------------- mid-operation reset ----------------
      do_reset();
      fill(5, 32'd300);
      check("t6_stored", 32'(dut.u_fifo.count), 32'd5);
      rst_n = 1'b0;
      #1;
      check("t6_rst_out_vld", 32'(bus.out_vld), 32'd0);
      check("t6_rst_up_rdy", 32'(bus.up_rdy), 32'd1);
      tick();
      check("t6_rst_credits", 32'(dut.credits), 32'd0);
      rst_n = 1'b1;
      #1 check("t6_unx_clear", 32'(bus.err_unx), 32'd0);
      bus.res_vld = 1'b1;
      bus.res     = 32'd9;
      tick();
      bus.res_vld = 1'b0;
      #1;
      check("t6_unx_after_reset", 32'(bus.err_unx), 32'd1);
      check("t6_no_output", 32'(bus.out_vld), 32'd0);

      // ---------------- empty-FIFO result with ready consumer ----------------
      do_reset();
      bus.up_vld = 1'b1;
      tick();
      bus.up_vld = 1'b0;
      tick();
      bus.res_vld = 1'b1;
      bus.res     = 32'h55;
      bus.out_rdy = 1'b1;
      #1;
`ifdef FORMULA_OUT_BUF_BYPASS_EN
      check("t7_bypass_vld", 32'(bus.out_vld), 32'd1);
      check("t7_bypass_data", bus.out_data, 32'h55);
      tick();
      bus.res_vld = 1'b0;
      bus.out_rdy = 1'b0;
      #1;
      check("t7_after_vld", 32'(bus.out_vld), 32'd0);
      check("t7_not_stored", 32'(dut.u_fifo.count), 32'd0);
`else
      check("t7_no_bypass", 32'(bus.out_vld), 32'd0);
      tick();
      bus.res_vld = 1'b0;
      #1;
      check("t7_latency1_vld", 32'(bus.out_vld), 32'd1);
      check("t7_latency1_data", bus.out_data, 32'h55);
      tick();
      bus.out_rdy = 1'b0;
      #1;
      check("t7_after_vld", 32'(bus.out_vld), 32'd0);
`endif
      check("t7_credits_zero", 32'(dut.credits), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/formula_2_out_buffer.md
# formula_2_out_buffer

Output buffer and credit controller placed directly downstream of `formula_2_pipe_using_fifos`. The formula pipe has a fixed latency and cannot stall, so this block decides when a new argument set may be issued. It issues only when it holds a free slot for the eventual result. It stores completed results in a FIFO and presents them to a consumer over a valid/ready handshake, converting the fixed-latency pipe into a back-pressurable stream.

## Interface
- `WIDTH`, 32, result width
- `DEPTH`, 8, result FIFO entries; power of two, ≥2
- `clk` in 1: sole clock, rising edge
- `rst` in 1: asynchronous, active-low reset; block in reset while 0
- `up_vld` in 1: producer offers argument set a/b/c (data goes straight to the pipe, not through this block)
- `up_rdy` out 1: block can accept an argument set this cycle
- `arg_vld` out 1: to pipe `arg_vld`; equals `up_vld & up_rdy`
- `res_vld` in 1: from pipe
- `res` in WIDTH: from pipe
- `out_vld` out 1: result available to consumer
- `out_data` out WIDTH: head result
- `out_rdy` in 1: consumer accepts
- `err_ovf` out 1: sticky; result arrived with FIFO full
- `err_unx` out 1: sticky; `res_vld` with zero results in flight

## Operation
- `credits` counter, range 0..DEPTH: number of issued-but-not-popped results.
  - +1 on issue (`arg_vld`); −1 on pop (`out_vld & out_rdy`); both in the same cycle leave it unchanged.
- `inflight` counter, range 0..DEPTH:
  - +1 on issue; −1 on `res_vld`.
  - Both in the same cycle leave it unchanged.
  - `res_vld` when `inflight==0`: set `err_unx`, drop `res`, hold the counter at 0.
- `up_rdy = (credits < DEPTH)`. Combinational from the `credits` register only; it never depends on `out_rdy`.
- Result FIFO behaviour:
  - Show-ahead storage with a write pointer, a read pointer and an occupancy count.
  - Pointers wrap modulo DEPTH.
  - `out_vld = !empty` and `out_data = mem[rd_ptr]`.
- Write on `res_vld`. If the FIFO is full and no pop occurs that cycle, drop the result and set `err_ovf`.
  - Simultaneous push and pop on a full FIFO succeeds, and occupancy stays at DEPTH.
- The credit invariant guarantees no overflow under correct pipe behaviour. The error flags exist for verification and debug only.
- `err_ovf` and `err_unx` clear only on reset.

## Timing
- Reset values:
  - Outputs: `up_rdy=1` (credits 0), `arg_vld=0` (follows `up_vld`), `out_vld=0`, `out_data=0`, `err_ovf=0`, `err_unx=0`.
  - Internal state: counters, pointers and mem are cleared.
- Reset asserted mid-operation discards all stored and in-flight results immediately. Any `res_vld` arriving after reset release without a new issue sets `err_unx`.
- Result written on edge N (when `res_vld` is high in the cycle before edge N) appears on `out_vld`/`out_data` in the cycle after edge N, i.e. one cycle of buffer latency.
- A pop at edge N frees a credit. `up_rdy` rises in the cycle after edge N.
- With DEPTH=8 and `out_rdy=0`, exactly 8 issues are accepted, after which `up_rdy=0` until the first pop.

## Configuration
- `FORMULA_OUT_BUF_BYPASS_EN` defined: when the FIFO is empty, `res_vld=1` and `out_rdy=1`, `res` is driven straight to `out_data` with `out_vld=1` in the same cycle. The result is not written, and the pop decrements `credits` as usual. Buffer latency becomes 0 in this case.
- Undefined: results always pass through storage, with a fixed buffer latency of 1.

## Structure
- Package `formula_2_pkg`:
  - `WIDTH` default constant.
  - `credit_t` typedef, sized `$clog2(DEPTH+1)`.
  - Pointer typedef, sized `$clog2(DEPTH)`.
- One sub-module, `formula_out_fifo`: storage, pointers, occupancy and full/empty. Credit, in-flight and error logic stay in the top module.

## Test plan
- Reset then a single issue: `up_vld=1` for 1 cycle, pipe returns `res=0x2A`. `out_vld` rises 1 cycle after `res_vld`, with `out_data=0x2A`; `credits` returns to 0 after the pop.
- Back-pressure fill: `out_rdy=0`, `up_vld=1` held.
  - Exactly 8 `arg_vld` pulses, then `up_rdy=0`.
  - After 8 results, one pop → `up_rdy=1` next cycle → 1 more issue.
- Streaming: `out_rdy=1`, `up_vld=1` for 100 cycles, results 1..100. `up_rdy` is never 0, output order is 1..100, and no error flag is set.
- Wrap plus simultaneous push/pop on a full FIFO: fill 8 entries, then for 20 cycles push and pop every cycle. Occupancy stays 8, data order is preserved across pointer wrap, and `err_ovf=0`.
- Error injection:
  - Force `res_vld` with `inflight=0` → `err_unx=1` and stays 1.
  - Force a 9th result into a full FIFO with no pop → `err_ovf=1` and the FIFO contents are unchanged.
- Mid-operation reset, then `FORMULA_OUT_BUF_BYPASS_EN`:
  - Reset with 5 results stored → `out_vld=0`, `up_rdy=1` while `rst=0`.
  - With the bypass macro, FIFO empty, `res_vld=1` and `out_rdy=1` → `out_vld=1`, `out_data=res` in the same cycle.
